// File: rtl/fir3p_output_serializer.sv
// fir3p_output_serializer
// Takes one block of three phase outputs per in_valid from the 3-parallel FIR,
// scales and saturates each phase to OUT_W bits, buffers up to DEPTH blocks and
// streams the samples out oldest-first over a valid/ready handshake.
// Sticky overflow plus drop/saturation counters are kept for the test harness.
module fir3p_output_serializer #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_phase0,
  input  logic [IN_W-1:0]  in_phase1,
  input  logic [IN_W-1:0]  in_phase2,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_sample,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sat,
  input  logic             clear_flags,
  output logic             overflow,
  output logic [15:0]      drop_cnt,
  output logic [15:0]      sat_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Largest / smallest representable output value, widened to the input width
  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Result is {clamped, sample}
  function automatic logic [OUT_W:0] sat_fn(input logic signed [IN_W-1:0] v);
    logic signed [IN_W-1:0] s;
    s = v >>> SHIFT;
    if (s > MAX_V)
      sat_fn = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    else if (s < MIN_V)
      sat_fn = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else
      sat_fn = {1'b0, s[OUT_W-1:0]};
  endfunction

  logic [3*OUT_W-1:0] blk_sample [DEPTH];
  logic [2:0]         blk_sat    [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [1:0]         ph;

  logic [OUT_W:0]     cap0, cap1, cap2;
  logic [1:0]         nclamp;
  logic [16:0]        sat_sum;
  logic [16:0]        drop_sum;
  logic               push, drop, pop, pop_last;

  assign out_valid = (count != '0);
  assign in_ready  = (count < DEPTH_C);
  assign push      = in_valid && (count < DEPTH_C);
  assign drop      = in_valid && (count == DEPTH_C);
  assign pop       = out_valid && out_ready;
  assign pop_last  = pop && (ph == 2'd2);

  // Scale/saturate the three incoming phases and total this block's clamps
  always_comb begin
    cap0     = sat_fn(in_phase0);
    cap1     = sat_fn(in_phase1);
    cap2     = sat_fn(in_phase2);
    nclamp   = {1'b0, cap0[OUT_W]} + {1'b0, cap1[OUT_W]} + {1'b0, cap2[OUT_W]};
    sat_sum  = {1'b0, sat_cnt} + {15'd0, nclamp};
    drop_sum = {1'b0, drop_cnt} + 17'd1;
  end

  // Present the head block entry selected by the phase index
  always_comb begin
    out_sample = blk_sample[rd_ptr][OUT_W-1:0];
    out_sat    = blk_sat[rd_ptr][0];
    case (ph)
      2'd1: begin
        out_sample = blk_sample[rd_ptr][2*OUT_W-1:OUT_W];
        out_sat    = blk_sat[rd_ptr][1];
      end
      2'd2: begin
        out_sample = blk_sample[rd_ptr][3*OUT_W-1:2*OUT_W];
        out_sat    = blk_sat[rd_ptr][2];
      end
      default: ;
    endcase
  end

  // Block storage; cleared on reset so the idle output reads as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        blk_sample[i] <= '0;
        blk_sat[i]    <= '0;
      end
    end else if (push) begin
      blk_sample[wr_ptr] <= {cap2[OUT_W-1:0], cap1[OUT_W-1:0], cap0[OUT_W-1:0]};
      blk_sat[wr_ptr]    <= {cap2[OUT_W], cap1[OUT_W], cap0[OUT_W]};
    end
  end

  // Pointers, occupancy and serial phase index; room test uses pre-edge count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ph     <= 2'd0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        if (ph == 2'd2) begin
          ph     <= 2'd0;
          rd_ptr <= rd_ptr + 1'b1;
        end else begin
          ph <= ph + 2'd1;
        end
      end
      count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop_last};
    end
  end

  // Sticky statistics; a clear in the same cycle as an event wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
      sat_cnt  <= '0;
    end else if (clear_flags) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
      sat_cnt  <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
      if (push)
        sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

endmodule

// File: tb/tb_fir3p_output_serializer.sv
// Testbench for fir3p_output_serializer: a sample-queue model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_fir3p_output_serializer;

  localparam int IN_W  = 64;
  localparam int OUT_W = 16;
  localparam int SHIFT = 0;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic [IN_W-1:0]    in_phase0 = '0, in_phase1 = '0, in_phase2 = '0;
  logic               in_ready;
  logic signed [OUT_W-1:0] out_sample;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               out_sat;
  logic               clear_flags = 1'b0;
  logic               overflow;
  logic [15:0]        drop_cnt;
  logic [15:0]        sat_cnt;

  fir3p_output_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_phase0(in_phase0), .in_phase1(in_phase1), .in_phase2(in_phase2),
    .in_ready(in_ready), .out_sample(out_sample), .out_valid(out_valid),
    .out_ready(out_ready), .out_sat(out_sat), .clear_flags(clear_flags),
    .overflow(overflow), .drop_cnt(drop_cnt), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { longint s; bit sat; } smp_t;

  smp_t   mq[$];
  longint got_s[$];
  bit     got_sat[$];
  longint expq[$];
  int     n_checks = 0;
  int     n_fail = 0;
  bit     m_ovf = 0;
  int     m_drop = 0;
  int     m_sat = 0;
  int     m_blocks;
  bit     m_push, m_pop;
  smp_t   c0, c1, c2;
  bit     prev_stall = 0;
  longint prev_sample = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic smp_t clamp(input longint v);
    smp_t r;
    longint s, hi, lo;
    s  = v >>> SHIFT;
    hi = (64'sd1 <<< (OUT_W-1)) - 1;
    lo = -(64'sd1 <<< (OUT_W-1));
    if (s > hi)      begin r.s = hi; r.sat = 1; end
    else if (s < lo) begin r.s = lo; r.sat = 1; end
    else             begin r.s = s;  r.sat = 0; end
    return r;
  endfunction

  // Model: FIFO of individual samples; block occupancy is the number of
  // (possibly partially drained) 3-sample blocks it holds.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_drop = 0; m_sat = 0;
    end else begin
      m_blocks = (mq.size() + 2) / 3;
      m_pop    = (mq.size() != 0) && out_ready;
      m_push   = in_valid && (m_blocks < DEPTH);
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        c0 = clamp($signed(in_phase0));
        c1 = clamp($signed(in_phase1));
        c2 = clamp($signed(in_phase2));
        mq.push_back(c0); mq.push_back(c1); mq.push_back(c2);
        m_sat = m_sat + c0.sat + c1.sat + c2.sat;
        if (m_sat > 65535) m_sat = 65535;
      end else if (in_valid) begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
      if (clear_flags) begin
        m_ovf = 0; m_drop = 0; m_sat = 0;
      end
    end
  end

  // Per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      chk("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("out_sample", out_sample, mq[0].s);
        chk("out_sat", out_sat, mq[0].sat);
      end
      chk("in_ready", in_ready, ((mq.size() + 2) / 3) < DEPTH);
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("sat_cnt", sat_cnt, m_sat);
      if (prev_stall) chk("stall_stable", out_sample, prev_sample);
      prev_stall  = out_valid && !out_ready;
      prev_sample = out_sample;
      if (out_valid && out_ready) begin
        got_s.push_back(out_sample);
        got_sat.push_back(out_sat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input longint a, input longint b, input longint c);
    in_valid  = 1'b1;
    in_phase0 = a; in_phase1 = b; in_phase2 = c;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && out_valid; i++) tick();
    chk("drain_timeout", out_valid, 0);
  endtask

  task automatic check_got(input string tag);
    chk({tag, "_count"}, got_s.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got_s.size(); i++)
      chk({tag, "_sample"}, got_s[i], expq[i]);
  endtask

  task automatic clear_got();
    got_s.delete();
    got_sat.delete();
  endtask

  initial begin
    tick(); tick();
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_sample", out_sample, 0);
    rst = 1'b0;
    tick();

    // 1: single block, free-running consumer
    out_ready = 1'b1;
    clear_got();
    send_block(5, -7, 100);
    drain();
    expq = '{5, -7, 100};
    check_got("t1");
    chk("t1_sat_cnt", sat_cnt, 0);

    // 2: clamping on capture
    clear_got();
    send_block(40000, -40000, 32767);
    drain();
    expq = '{32767, -32768, 32767};
    check_got("t2");
    if (got_sat.size() == 3) begin
      chk("t2_sat0", got_sat[0], 1);
      chk("t2_sat1", got_sat[1], 1);
      chk("t2_sat2", got_sat[2], 0);
    end else begin
      chk("t2_sat_count", got_sat.size(), 3);
    end
    chk("t2_sat_cnt", sat_cnt, 2);

    // 3: fill with consumer stalled, fifth block dropped, then drain
    out_ready = 1'b0;
    clear_got();
    for (int b = 1; b <= 4; b++) send_block(b*10, b*10+1, b*10+2);
    chk("t3_in_ready_full", in_ready, 0);
    send_block(50, 51, 52);
    chk("t3_overflow", overflow, 1);
    chk("t3_drop_cnt", drop_cnt, 1);
    out_ready = 1'b1;
    drain();
    expq = '{10, 11, 12, 20, 21, 22, 30, 31, 32, 40, 41, 42};
    check_got("t3");

    // 4: toggling backpressure over two blocks
    out_ready = 1'b0;
    clear_got();
    send_block(100, 101, 102);
    send_block(200, 201, 202);
    for (int i = 0; i < 60 && out_valid; i++) begin
      out_ready = ~out_ready;
      tick();
    end
    chk("t4_timeout", out_valid, 0);
    expq = '{100, 101, 102, 200, 201, 202};
    check_got("t4");

    // 5: reset after phase1 popped
    out_ready = 1'b1;
    clear_got();
    send_block(7, 8, 9);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_sample", out_sample, 0);
    chk("t5_out_sat", out_sat, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_overflow", overflow, 0);
    chk("t5_drop_cnt", drop_cnt, 0);
    chk("t5_sat_cnt", sat_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    clear_got();
    send_block(1, 2, 3);
    drain();
    expq = '{1, 2, 3};
    check_got("t5");

    // 6: clear_flags coincident with a drop
    out_ready = 1'b0;
    for (int b = 1; b <= 4; b++) send_block(b, b+1, b+2);
    for (int b = 0; b < 3; b++) send_block(-1, -2, -3);
    chk("t6_drop_cnt3", drop_cnt, 3);
    chk("t6_overflow1", overflow, 1);
    clear_flags = 1'b1;
    send_block(-4, -5, -6);
    clear_flags = 1'b0;
    chk("t6_drop_cnt0", drop_cnt, 0);
    chk("t6_overflow0", overflow, 0);
    out_ready = 1'b1;
    clear_got();
    drain();
    chk("t6_drained", got_s.size(), 12);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got %0d checks expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule
